// File: rtl/ring_router_mux.sv
// ring_router_mux: packet-atomic 2:1 merge of ring through-traffic and local DII injection onto the next ring segment.
// Latency: 1 cycle through the output register; 1 flit/cycle while out_mux_ready stays high.
// Backpressure: only the selected input sees ready, and only while the output register can load; a stalled out_mux holds its flit.
// Optional: define RING_MUX_FAIRNESS_EN to let a waiting local packet in after MAX_RING_PKTS ring packets.

package dii_pkg;
  typedef struct packed {
    logic [15:0] data;
    logic        last;
    logic        valid;
  } dii_flit;
endpackage

module ring_router_mux
  import dii_pkg::*;
#(
  parameter int unsigned MAX_RING_PKTS = 4
) (
  input  logic    clk,
  input  logic    rst,
  input  dii_flit in_ring,
  output logic    in_ring_ready,
  input  dii_flit in_local,
  output logic    in_local_ready,
  output dii_flit out_mux,
  input  logic    out_mux_ready
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RING  = 2'd1,
    LOCAL = 2'd2
  } state_t;

  state_t state_q;
  state_t state_d;

  logic sel_ring;
  logic sel_local;
  logic can_load;
  logic ring_acc;
  logic local_acc;
  logic force_local;

  // The register may take a new flit when empty or when its current flit leaves this cycle.
  assign can_load = !out_mux.valid || out_mux_ready;

  // Nothing is accepted while reset is held, so a flit cannot slip in during reset.
  assign in_ring_ready  = !rst && can_load && sel_ring;
  assign in_local_ready = !rst && can_load && sel_local;

  assign ring_acc  = in_ring.valid  && in_ring_ready;
  assign local_acc = in_local.valid && in_local_ready;

  // Source selection: IDLE arbitrates this cycle, RING/LOCAL stay locked to the packet owner.
  always_comb begin
    sel_ring  = 1'b0;
    sel_local = 1'b0;
    case (state_q)
      IDLE: begin
        if (force_local) begin
          sel_local = 1'b1;
        end else if (in_ring.valid) begin
          sel_ring = 1'b1;
        end else if (in_local.valid) begin
          sel_local = 1'b1;
        end
      end
      RING:    sel_ring  = 1'b1;
      LOCAL:   sel_local = 1'b1;
      default: ;
    endcase
  end

  // Next state: lock on a non-last flit, release after the owner's last flit.
  always_comb begin
    state_d = state_q;
    if (ring_acc) begin
      state_d = in_ring.last ? IDLE : RING;
    end else if (local_acc) begin
      state_d = in_local.last ? IDLE : LOCAL;
    end else if (state_q != IDLE && state_q != RING && state_q != LOCAL) begin
      state_d = IDLE;
    end
  end

  // State register; reset abandons any partial packet.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Output register: load the accepted flit, otherwise drop valid once downstream has taken it.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_mux <= '0;
    end else if (ring_acc) begin
      out_mux <= in_ring;
    end else if (local_acc) begin
      out_mux <= in_local;
    end else if (out_mux_ready) begin
      out_mux.valid <= 1'b0;
    end
  end

`ifdef RING_MUX_FAIRNESS_EN
  localparam logic [7:0] MAX_CNT = 8'(MAX_RING_PKTS);

  logic [7:0] fair_cnt;

  // Count ring packets finished while local was waiting; a finished local packet clears it.
  always_ff @(posedge clk) begin
    if (rst) begin
      fair_cnt <= 8'd0;
    end else if (local_acc && in_local.last) begin
      fair_cnt <= 8'd0;
    end else if (ring_acc && in_ring.last && in_local.valid && fair_cnt < MAX_CNT) begin
      fair_cnt <= fair_cnt + 8'd1;
    end
  end

  // Only consulted in IDLE, so an in-progress ring packet is never preempted.
  assign force_local = (fair_cnt == MAX_CNT) && in_local.valid;
`else
  assign force_local = 1'b0;
`endif

endmodule

// File: tb/tb_ring_router_mux.sv
// tb_ring_router_mux: directed cycle table plus randomized traffic against a packet-level reference model.
// Latency: checks readies and out_mux at the falling edge, one cycle after the accepting rising edge.
// Backpressure: random out_mux_ready stalls and dropped upstream valids.
module tb_ring_router_mux;
  import dii_pkg::*;

  localparam int unsigned MAXP = 2;
`ifdef RING_MUX_FAIRNESS_EN
  localparam bit FAIR = 1'b1;
`else
  localparam bit FAIR = 1'b0;
`endif

  logic    clk;
  logic    rst;
  dii_flit in_ring;
  logic    in_ring_ready;
  dii_flit in_local;
  logic    in_local_ready;
  dii_flit out_mux;
  logic    out_mux_ready;

  int n_checks = 0;
  int n_pass   = 0;

  ring_router_mux #(.MAX_RING_PKTS(MAXP)) dut (
    .clk            (clk),
    .rst            (rst),
    .in_ring        (in_ring),
    .in_ring_ready  (in_ring_ready),
    .in_local       (in_local),
    .in_local_ready (in_local_ready),
    .out_mux        (out_mux),
    .out_mux_ready  (out_mux_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        rst;
    logic        rv;
    logic [15:0] rd;
    logic        rl;
    logic        lv;
    logic [15:0] ld;
    logic        ll;
    logic        ordy;
    logic        err;
    logic        elr;
    logic        eov;
    logic [15:0] eod;
    logic        eol;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic rst_i, input logic rv, input logic [15:0] rd, input logic rl,
                              input logic lv, input logic [15:0] ld, input logic ll, input logic ordy,
                              input logic err, input logic elr, input logic eov, input logic [15:0] eod,
                              input logic eol);
    vec_t v;
    v.rst = rst_i; v.rv = rv; v.rd = rd; v.rl = rl;
    v.lv = lv; v.ld = ld; v.ll = ll; v.ordy = ordy;
    v.err = err; v.elr = elr; v.eov = eov; v.eod = eod; v.eol = eol;
    return v;
  endfunction

  function automatic logic [15:0] gdata(input int src, input int pkt, input int idx);
    logic [15:0] d;
    d = {src[0], 11'(pkt), 4'(idx)};
    return d;
  endfunction

  // reference model state (packet owner, output slot, fairness tally)
  int          owner;
  dii_flit     m_out;
  int unsigned fcnt;
  int          out_owner;
  logic [16:0] sb_ring[$];
  logic [16:0] sb_loc[$];

  initial begin
    logic rv, lv, ordy, can_load, e_rr, e_lr, acc_r, acc_l, drain, src;
    int   sel;
    int   r_pkt, r_idx, r_len, l_pkt, l_idx, l_len;
    logic [16:0] expf;
    dii_flit rf, lf;

    rst = 1'b1;
    in_ring = '0;
    in_local = '0;
    out_mux_ready = 1'b0;
    @(posedge clk); #1;

    // single flit, atomicity, backpressure, priority, reset mid-packet, fairness
    vecs.push_back(mk(1, 0,16'h0,0,      1,16'hA5A5,1, 1, 0,0, 0,16'h0,0));
    vecs.push_back(mk(0, 0,16'h0,0,      1,16'hA5A5,1, 1, 0,1, 0,16'h0,0));
    vecs.push_back(mk(0, 0,16'h0,0,      0,16'h0,0,    1, 0,0, 1,16'hA5A5,1));
    vecs.push_back(mk(0, 0,16'h0,0,      0,16'h0,0,    1, 0,0, 0,16'h0,0));
    vecs.push_back(mk(0, 0,16'h0,0,      1,16'h1,0,    1, 0,1, 0,16'h0,0));
    vecs.push_back(mk(0, 1,16'h0100,0,   1,16'h2,0,    1, 0,1, 1,16'h1,0));
    vecs.push_back(mk(0, 1,16'h0100,0,   1,16'h3,1,    1, 0,1, 1,16'h2,0));
    vecs.push_back(mk(0, 1,16'h0100,0,   0,16'h0,0,    1, 1,0, 1,16'h3,1));
    vecs.push_back(mk(0, 1,16'h0101,1,   0,16'h0,0,    1, 1,0, 1,16'h0100,0));
    vecs.push_back(mk(0, 0,16'h0,0,      0,16'h0,0,    1, 0,0, 1,16'h0101,1));
    vecs.push_back(mk(0, 0,16'h0,0,      0,16'h0,0,    1, 0,0, 0,16'h0,0));
    vecs.push_back(mk(0, 1,16'h0200,0,   0,16'h0,0,    1, 1,0, 0,16'h0,0));
    vecs.push_back(mk(0, 1,16'h0201,0,   0,16'h0,0,    1, 1,0, 1,16'h0200,0));
    vecs.push_back(mk(0, 1,16'h0202,0,   0,16'h0,0,    0, 0,0, 1,16'h0201,0));
    vecs.push_back(mk(0, 1,16'h0202,0,   0,16'h0,0,    0, 0,0, 1,16'h0201,0));
    vecs.push_back(mk(0, 1,16'h0202,0,   0,16'h0,0,    0, 0,0, 1,16'h0201,0));
    vecs.push_back(mk(0, 1,16'h0202,0,   0,16'h0,0,    1, 1,0, 1,16'h0201,0));
    vecs.push_back(mk(0, 1,16'h0203,1,   0,16'h0,0,    1, 1,0, 1,16'h0202,0));
    vecs.push_back(mk(0, 0,16'h0,0,      0,16'h0,0,    1, 0,0, 1,16'h0203,1));
    vecs.push_back(mk(0, 0,16'h0,0,      0,16'h0,0,    1, 0,0, 0,16'h0,0));
    vecs.push_back(mk(0, 1,16'h0300,0,   1,16'h0400,0, 1, 1,0, 0,16'h0,0));
    vecs.push_back(mk(0, 1,16'h0301,1,   1,16'h0400,0, 1, 1,0, 1,16'h0300,0));
    vecs.push_back(mk(0, 0,16'h0,0,      1,16'h0400,0, 1, 0,1, 1,16'h0301,1));
    vecs.push_back(mk(0, 0,16'h0,0,      1,16'h0401,1, 1, 0,1, 1,16'h0400,0));
    vecs.push_back(mk(0, 0,16'h0,0,      0,16'h0,0,    1, 0,0, 1,16'h0401,1));
    vecs.push_back(mk(0, 0,16'h0,0,      0,16'h0,0,    1, 0,0, 0,16'h0,0));
    vecs.push_back(mk(0, 1,16'h0500,0,   0,16'h0,0,    1, 1,0, 0,16'h0,0));
    vecs.push_back(mk(0, 1,16'h0501,0,   0,16'h0,0,    1, 1,0, 1,16'h0500,0));
    vecs.push_back(mk(1, 1,16'h0502,0,   0,16'h0,0,    0, 0,0, 1,16'h0501,0));
    vecs.push_back(mk(0, 0,16'h0,0,      1,16'h0600,1, 0, 0,1, 0,16'h0,0));
    vecs.push_back(mk(0, 0,16'h0,0,      0,16'h0,0,    1, 0,0, 1,16'h0600,1));
    vecs.push_back(mk(0, 0,16'h0,0,      0,16'h0,0,    1, 0,0, 0,16'h0,0));
    vecs.push_back(mk(0, 1,16'h0700,1,   1,16'h0800,1, 1, 1,0, 0,16'h0,0));
    vecs.push_back(mk(0, 1,16'h0701,1,   1,16'h0800,1, 1, 1,0, 1,16'h0700,1));
    vecs.push_back(mk(0, 1,16'h0702,1,   1,16'h0800,1, 1, !FAIR,FAIR, 1,16'h0701,1));
    vecs.push_back(mk(0, 1,16'h0703,1,   0,16'h0,0,    1, 1,0, 1,(FAIR ? 16'h0800 : 16'h0702),1));
    vecs.push_back(mk(0, 0,16'h0,0,      0,16'h0,0,    1, 0,0, 1,16'h0703,1));
    vecs.push_back(mk(0, 0,16'h0,0,      0,16'h0,0,    1, 0,0, 0,16'h0,0));

    for (int i = 0; i < vecs.size(); i++) begin
      rst = vecs[i].rst;
      in_ring  = '{data: vecs[i].rd, last: vecs[i].rl, valid: vecs[i].rv};
      in_local = '{data: vecs[i].ld, last: vecs[i].ll, valid: vecs[i].lv};
      out_mux_ready = vecs[i].ordy;
      @(negedge clk);
      chk($sformatf("v%0d_in_ring_ready", i), 32'(in_ring_ready), 32'(vecs[i].err));
      chk($sformatf("v%0d_in_local_ready", i), 32'(in_local_ready), 32'(vecs[i].elr));
      chk($sformatf("v%0d_out_valid", i), 32'(out_mux.valid), 32'(vecs[i].eov));
      if (vecs[i].eov) begin
        chk($sformatf("v%0d_out_data", i), 32'(out_mux.data), 32'(vecs[i].eod));
        chk($sformatf("v%0d_out_last", i), 32'(out_mux.last), 32'(vecs[i].eol));
      end
      @(posedge clk); #1;
    end

    // randomized traffic against the reference model
    rst = 1'b1;
    in_ring = '0;
    in_local = '0;
    out_mux_ready = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    owner = 0; m_out = '0; fcnt = 0; out_owner = -1;
    r_pkt = 0; r_idx = 0; r_len = $urandom_range(1, 4);
    l_pkt = 0; l_idx = 0; l_len = $urandom_range(1, 4);

    for (int c = 0; c < 3000; c++) begin
      drain = (c >= 2950);
      rv   = !drain && ($urandom_range(0, 99) < 60);
      lv   = !drain && ($urandom_range(0, 99) < 45);
      ordy = drain || ($urandom_range(0, 99) < 70);
      rf = '{data: gdata(0, r_pkt, r_idx), last: (r_idx == r_len - 1), valid: rv};
      lf = '{data: gdata(1, l_pkt, l_idx), last: (l_idx == l_len - 1), valid: lv};
      in_ring = rf;
      in_local = lf;
      out_mux_ready = ordy;
      @(negedge clk);

      can_load = !m_out.valid || ordy;
      if (owner != 0) sel = owner;
      else if (FAIR && fcnt == MAXP && lv) sel = 2;
      else if (rv) sel = 1;
      else if (lv) sel = 2;
      else sel = 0;
      e_rr = can_load && (sel == 1);
      e_lr = can_load && (sel == 2);
      chk("rnd_in_ring_ready", 32'(in_ring_ready), 32'(e_rr));
      chk("rnd_in_local_ready", 32'(in_local_ready), 32'(e_lr));
      chk("rnd_out_valid", 32'(out_mux.valid), 32'(m_out.valid));
      if (m_out.valid) begin
        chk("rnd_out_data", 32'(out_mux.data), 32'(m_out.data));
        chk("rnd_out_last", 32'(out_mux.last), 32'(m_out.last));
      end

      // packet-level scoreboard: per-source order and no interleaving on out_mux
      if (out_mux.valid && ordy) begin
        src = out_mux.data[15];
        if (out_owner >= 0) chk("rnd_atomic_src", 32'(src), 32'(out_owner));
        if (src == 1'b0) begin
          chk("rnd_sb_ring_nonempty", 32'(sb_ring.size() > 0), 32'd1);
          if (sb_ring.size() > 0) begin
            expf = sb_ring.pop_front();
            chk("rnd_sb_ring_flit", 32'({out_mux.last, out_mux.data}), 32'(expf));
          end
        end else begin
          chk("rnd_sb_local_nonempty", 32'(sb_loc.size() > 0), 32'd1);
          if (sb_loc.size() > 0) begin
            expf = sb_loc.pop_front();
            chk("rnd_sb_local_flit", 32'({out_mux.last, out_mux.data}), 32'(expf));
          end
        end
        out_owner = out_mux.last ? -1 : int'(src);
      end

      acc_r = rv && e_rr;
      acc_l = lv && e_lr;
      if (acc_r) begin
        m_out = rf;
        owner = rf.last ? 0 : 1;
        if (rf.last && lv && fcnt < MAXP) fcnt++;
        sb_ring.push_back({rf.last, rf.data});
        if (rf.last) begin
          r_pkt++; r_idx = 0; r_len = $urandom_range(1, 4);
        end else begin
          r_idx++;
        end
      end else if (acc_l) begin
        m_out = lf;
        owner = lf.last ? 0 : 2;
        if (lf.last) fcnt = 0;
        sb_loc.push_back({lf.last, lf.data});
        if (lf.last) begin
          l_pkt++; l_idx = 0; l_len = $urandom_range(1, 4);
        end else begin
          l_idx++;
        end
      end else if (ordy) begin
        m_out.valid = 1'b0;
      end
      @(posedge clk); #1;
    end

    chk("rnd_ring_all_delivered", 32'(sb_ring.size()), 32'd0);
    chk("rnd_local_all_delivered", 32'(sb_loc.size()), 32'd0);
    chk("rnd_ring_traffic_seen", 32'(r_pkt > 20), 32'd1);
    chk("rnd_local_traffic_seen", 32'(l_pkt > 20), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
